// File: rtl/sysctrl_host.sv
// Host-side initiator for the MCU system-control byte stream: one framed transaction per
// start (command byte, then len payload slots), collecting one response byte per slot.
module sysctrl_host #(
  parameter int unsigned GAP   = 2,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             tx_req,
  input  logic [7:0]       tx_data,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             data_in_strobe,
  output logic             data_in_start,
  output logic [7:0]       data_in,
  input  logic [7:0]       data_out
);

  localparam int unsigned GAP_W = 4;

  if (GAP < 1 || GAP > 15) begin : g_gap_check
    $error("sysctrl_host: GAP must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_FETCH
  } state_t;

  state_t           state_q, state_d;
  logic             busy_d, done_d, tx_req_d, rx_valid_d;
  logic             strobe_d, start_flag_d;
  logic [7:0]       data_in_d, rx_data_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic             first_q, first_d;

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      tx_req         <= 1'b0;
      rx_valid       <= 1'b0;
      data_in_strobe <= 1'b0;
      data_in_start  <= 1'b0;
      data_in        <= 8'h00;
      rx_data        <= 8'h00;
      remaining_q    <= '0;
      gapcnt_q       <= '0;
      first_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy           <= busy_d;
      done           <= done_d;
      tx_req         <= tx_req_d;
      rx_valid       <= rx_valid_d;
      data_in_strobe <= strobe_d;
      data_in_start  <= start_flag_d;
      data_in        <= data_in_d;
      rx_data        <= rx_data_d;
      remaining_q    <= remaining_d;
      gapcnt_q       <= gapcnt_d;
      first_q        <= first_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy;
    done_d       = 1'b0;
    tx_req_d     = 1'b0;
    rx_valid_d   = 1'b0;
    strobe_d     = 1'b0;
    start_flag_d = 1'b0;
    data_in_d    = data_in;
    rx_data_d    = rx_data;
    remaining_d  = remaining_q;
    gapcnt_d     = gapcnt_q;
    first_d      = first_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_in_d    = cmd;
          strobe_d     = 1'b1;
          start_flag_d = 1'b1;
          busy_d       = 1'b1;
          remaining_d  = len;
          gapcnt_d     = GAP_W'(GAP);
          first_d      = 1'b1;
          state_d      = S_GAP;
        end
      end

      S_GAP: begin
        gapcnt_d = gapcnt_q - GAP_W'(1);
        if (gapcnt_q == GAP_W'(1)) begin
          // The command slot has no response of its own; only payload slots report.
          if (!first_q) begin
            rx_data_d  = data_out;
            rx_valid_d = 1'b1;
          end
          if (remaining_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tx_req_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        data_in_d    = tx_data;
        strobe_d     = 1'b1;
        start_flag_d = 1'b0;
        remaining_d  = remaining_q - LEN_W'(1);
        first_d      = 1'b0;
        gapcnt_d     = GAP_W'(GAP);
        state_d      = S_GAP;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sysctrl_host.sv
// Bench for sysctrl_host: two instances (GAP=2 and GAP=1) share a responder model and a
// queue-based scoreboard of expected strobes and response bytes.
module tb_sysctrl_host;
  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic reset, start, sel;
  logic [7:0] cmd, tx_data, data_out;
  logic [LEN_W-1:0] len;
  logic start0, start1;

  logic busy0, done0, tx_req0, rx_valid0, strobe0, sflag0;
  logic [7:0] rx_data0, din0;
  logic busy1, done1, tx_req1, rx_valid1, strobe1, sflag1;
  logic [7:0] rx_data1, din1;

  logic m_busy, m_done, m_tx_req, m_rx_valid, m_strobe, m_sflag;
  logic [7:0] m_rxd, m_din;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int txreq_cnt = 0;
  logic tx_req_prev;

  logic [8:0] din_q[$];
  int         scyc_q[$];
  logic [7:0] rx_q[$];
  int         rxcyc_q[$];
  logic [7:0] pay_q[$];

  logic [7:0] r_cmd;
  logic [4:0] r_idx;
  logic       released;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  assign m_busy     = sel ? busy1     : busy0;
  assign m_done     = sel ? done1     : done0;
  assign m_tx_req   = sel ? tx_req1   : tx_req0;
  assign m_rx_valid = sel ? rx_valid1 : rx_valid0;
  assign m_strobe   = sel ? strobe1   : strobe0;
  assign m_sflag    = sel ? sflag1    : sflag0;
  assign m_rxd      = sel ? rx_data1  : rx_data0;
  assign m_din      = sel ? din1      : din0;

  sysctrl_host #(.GAP(2), .LEN_W(LEN_W)) u_gap2 (
    .clk(clk), .reset(reset), .start(start0), .cmd(cmd), .len(len),
    .busy(busy0), .done(done0), .tx_req(tx_req0), .tx_data(tx_data),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .data_in_strobe(strobe0),
    .data_in_start(sflag0), .data_in(din0), .data_out(data_out)
  );

  sysctrl_host #(.GAP(1), .LEN_W(LEN_W)) u_gap1 (
    .clk(clk), .reset(reset), .start(start1), .cmd(cmd), .len(len),
    .busy(busy1), .done(done1), .tx_req(tx_req1), .tx_data(tx_data),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .data_in_strobe(strobe1),
    .data_in_start(sflag1), .data_in(din1), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: the command strobe loads response 0, payload strobe n loads response n.
  function automatic logic [7:0] resp(input logic [7:0] c, input int n);
    if (c == 8'h08) return 8'(32 + 5 * n);
    if (n == 0) return 8'hA5;
    if (c == 8'h00) begin
      case (n)
        1: return 8'h5C;
        2: return 8'h42;
        default: return 8'h00;
      endcase
    end
    return 8'hAC;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= 8'h00;
      r_cmd    <= 8'h00;
      r_idx    <= 5'd0;
      released <= 1'b0;
    end else if (m_strobe) begin
      if (m_sflag) begin
        r_cmd    <= m_din;
        r_idx    <= 5'd1;
        data_out <= resp(m_din, 0);
      end else begin
        r_idx    <= r_idx + 5'd1;
        data_out <= resp(r_cmd, int'(r_idx));
        if (r_cmd == 8'h04 && m_din == 8'h52) released <= 1'b1;
      end
    end
  end

  // Payload driver and scoreboard monitor, both on the falling edge.
  initial begin
    logic [8:0] exp9;
    logic [7:0] exp_rx;
    int ec;
    tx_data = 8'h00;
    tx_req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_tx_req) begin
        txreq_cnt++;
        tx_data = (pay_q.size() > 0) ? pay_q.pop_front() : 8'hEE;
      end
      if (m_strobe) begin
        total++;
        if (din_q.size() == 0) begin
          bad++;
          $display("FAIL strobe_extra: got start=%b data_in=%h at cycle %0d, required no strobe",
                   m_sflag, m_din, cyc);
        end else begin
          exp9 = din_q.pop_front();
          ec = scyc_q.pop_front();
          if ({m_sflag, m_din} !== exp9 || cyc != ec) begin
            bad++;
            $display("FAIL strobe: got start=%b data_in=%h cycle=%0d, required start=%b data_in=%h cycle=%0d",
                     m_sflag, m_din, cyc, exp9[8], exp9[7:0], ec);
          end
        end
        if (!m_sflag) begin
          total++;
          if (tx_req_prev !== 1'b1) begin
            bad++;
            $display("FAIL txreq_lead: got tx_req=%b the cycle before strobe %0d, required 1",
                     tx_req_prev, cyc);
          end
        end
      end
      if (m_sflag) begin
        total++;
        if (m_strobe !== 1'b1) begin
          bad++;
          $display("FAIL start_flag: got data_in_strobe=%b with data_in_start=1, required 1", m_strobe);
        end
      end
      if (m_rx_valid) begin
        total++;
        if (rx_q.size() == 0) begin
          bad++;
          $display("FAIL rx_extra: got rx_data=%h at cycle %0d, required no rx_valid", m_rxd, cyc);
        end else begin
          exp_rx = rx_q.pop_front();
          ec = rxcyc_q.pop_front();
          if (m_rxd !== exp_rx || cyc != ec) begin
            bad++;
            $display("FAIL rx: got rx_data=%h cycle=%0d, required rx_data=%h cycle=%0d",
                     m_rxd, cyc, exp_rx, ec);
          end
        end
      end
      tx_req_prev = m_tx_req;
    end
  end

  // Called at a falling edge with pay_q holding exactly l payload bytes.
  task automatic launch(input logic [7:0] c, input int l, output int t0);
    int g, lag;
    g = sel ? 1 : 2;
    // With GAP=1 the host samples data_out in the strobe cycle, before the responder reacts.
    lag = (g == 1) ? 1 : 0;
    t0 = cyc;
    start = 1'b1;
    cmd = c;
    len = LEN_W'(l);
    din_q.push_back({1'b1, c});
    scyc_q.push_back(t0 + 1);
    for (int k = 1; k <= l; k++) begin
      din_q.push_back({1'b0, pay_q[k-1]});
      scyc_q.push_back(t0 + 1 + k * (g + 1));
      rx_q.push_back(resp(c, k - lag));
      rxcyc_q.push_back(t0 + 1 + k * (g + 1) + g);
    end
    txreq_cnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (m_done === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy0, done0, tx_req0, rx_valid0, strobe0, sflag0, din0, rx_data0} !== 22'd0) begin
      bad++;
      $display("FAIL reset_gap2: got outputs=%h, required 0",
               {busy0, done0, tx_req0, rx_valid0, strobe0, sflag0, din0, rx_data0});
    end
    total++;
    if ({busy1, done1, tx_req1, rx_valid1, strobe1, sflag1, din1, rx_data1} !== 22'd0) begin
      bad++;
      $display("FAIL reset_gap1: got outputs=%h, required 0",
               {busy1, done1, tx_req1, rx_valid1, strobe1, sflag1, din1, rx_data1});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_id();
    int t0, at;
    sel = 1'b0;
    pay_q.delete();
    for (int k = 0; k < 3; k++) pay_q.push_back(8'h00);
    launch(8'h00, 3, t0);
    wait_done(at);
    total++;
    if (at != t0 + 12) begin
      bad++;
      $display("FAIL read_id_done: got done at cycle %0d, required %0d", at, t0 + 12);
    end
    total++;
    if (txreq_cnt != 3) begin
      bad++;
      $display("FAIL read_id_txreq: got %0d tx_req pulses, required 3", txreq_cnt);
    end
    @(negedge clk);
    total++;
    if (din_q.size() != 0 || rx_q.size() != 0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL read_id_drain: got strobes_left=%0d rx_left=%0d busy=%b, required 0 0 0",
               din_q.size(), rx_q.size(), m_busy);
    end
  endtask

  task automatic test_release();
    int t0, at;
    sel = 1'b0;
    total++;
    if (released !== 1'b0) begin
      bad++;
      $display("FAIL release_pre: got released=%b, required 0", released);
    end
    pay_q.delete();
    pay_q.push_back(8'h52);
    pay_q.push_back(8'h00);
    launch(8'h04, 2, t0);
    wait_done(at);
    total++;
    if (at != t0 + 9) begin
      bad++;
      $display("FAIL release_done: got done at cycle %0d, required %0d", at, t0 + 9);
    end
    total++;
    if (txreq_cnt != 2) begin
      bad++;
      $display("FAIL release_txreq: got %0d tx_req pulses, required 2", txreq_cnt);
    end
    @(negedge clk);
    total++;
    if (released !== 1'b1) begin
      bad++;
      $display("FAIL release_flag: got released=%b, required 1", released);
    end
  endtask

  task automatic test_cmd_only();
    int t0;
    sel = 1'b0;
    pay_q.delete();
    launch(8'h01, 0, t0);
    for (int j = 1; j <= 3; j++) begin
      total++;
      if (m_busy !== (j < 3) || m_done !== (j == 3)) begin
        bad++;
        $display("FAIL cmd_only_c%0d: got busy=%b done=%b, required busy=%b done=%b",
                 j, m_busy, m_done, j < 3, j == 3);
      end
      @(negedge clk);
    end
    total++;
    if (txreq_cnt != 0 || din_q.size() != 0 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL cmd_only_drain: got tx_req=%0d strobes_left=%0d rx_left=%0d, required 0 0 0",
               txreq_cnt, din_q.size(), rx_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    int t0, t1, at;
    sel = 1'b0;
    pay_q.delete();
    pay_q.push_back(8'h00);
    launch(8'h00, 1, t0);
    for (int p = 0; p < 2; p++) begin
      while (cyc < t0 + 3 + 2 * p) @(negedge clk);
      total++;
      if (m_busy !== 1'b1) begin
        bad++;
        $display("FAIL ignore_busy%0d: got busy=%b at stray start, required 1", p, m_busy);
      end
      start = 1'b1;
      cmd = (p == 0) ? 8'h77 : 8'h66;
      len = LEN_W'(5);
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (m_done !== 1'b1 || cyc != t0 + 6) begin
      bad++;
      $display("FAIL ignore_done: got done=%b at cycle %0d, required 1 at %0d", m_done, cyc, t0 + 6);
    end
    @(negedge clk);
    launch(8'h01, 0, t1);
    wait_done(at);
    total++;
    if (at != t1 + 3) begin
      bad++;
      $display("FAIL ignore_restart: got done at cycle %0d, required %0d", at, t1 + 3);
    end
    @(negedge clk);
    total++;
    if (din_q.size() != 0 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL ignore_drain: got strobes_left=%0d rx_left=%0d, required 0 0",
               din_q.size(), rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, t1, at;
    sel = 1'b0;
    pay_q.delete();
    for (int k = 1; k <= 4; k++) pay_q.push_back(8'(k * 17));
    launch(8'h00, 4, t0);
    while (cyc < t0 + 8) @(negedge clk);
    total++;
    if (m_busy !== 1'b1 || m_din !== 8'h22) begin
      bad++;
      $display("FAIL mid_pre: got busy=%b data_in=%h, required 1 22", m_busy, m_din);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({m_busy, m_done, m_tx_req, m_rx_valid, m_strobe, m_sflag, m_din, m_rxd} !== 22'd0) begin
      bad++;
      $display("FAIL mid_reset: got outputs=%h, required 0",
               {m_busy, m_done, m_tx_req, m_rx_valid, m_strobe, m_sflag, m_din, m_rxd});
    end
    din_q.delete();
    scyc_q.delete();
    rx_q.delete();
    rxcyc_q.delete();
    pay_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) pay_q.push_back(8'h00);
    launch(8'h00, 3, t1);
    wait_done(at);
    total++;
    if (at != t1 + 12) begin
      bad++;
      $display("FAIL mid_after: got done at cycle %0d, required %0d", at, t1 + 12);
    end
    @(negedge clk);
    total++;
    if (din_q.size() != 0 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL mid_drain: got strobes_left=%0d rx_left=%0d, required 0 0",
               din_q.size(), rx_q.size());
    end
  endtask

  task automatic test_gap1_menu();
    int t0, at;
    sel = 1'b1;
    pay_q.delete();
    for (int k = 0; k < 15; k++) pay_q.push_back(8'(8'hC0 + k));
    launch(8'h08, 15, t0);
    wait_done(at);
    total++;
    if (at != t0 + 32) begin
      bad++;
      $display("FAIL menu_done: got done at cycle %0d, required %0d", at, t0 + 32);
    end
    total++;
    if (txreq_cnt != 15) begin
      bad++;
      $display("FAIL menu_txreq: got %0d tx_req pulses, required 15", txreq_cnt);
    end
    repeat (6) @(negedge clk);
    total++;
    if (m_busy !== 1'b0 || din_q.size() != 0 || rx_q.size() != 0) begin
      bad++;
      $display("FAIL menu_drain: got busy=%b strobes_left=%0d rx_left=%0d, required 0 0 0",
               m_busy, din_q.size(), rx_q.size());
    end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel = 1'b0;
    cmd = 8'h00;
    len = '0;
    test_reset();
    test_read_id();
    test_release();
    test_cmd_only();
    test_busy_ignore();
    test_reset_mid();
    test_gap1_menu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
